// File: rtl/ula_seq.sv
// ula_seq: sequential arithmetic/logic unit with a three-state control FSM.
//   Single-cycle ops (add, sub, AND, OR, XOR, div-by-zero, illegal op) finish
//   on the accepting edge. Multiply (shift-add) and divide (restoring) run for
//   WIDTH cycles, one step per cycle, with busy high.
// Ports:
//   clk      - system clock, rising edge
//   rst      - asynchronous active-high reset
//   start    - operation request, accepted only in IDLE
//   a, b     - unsigned operands, WIDTH bits
//   op       - operation select (4 bits)
//   busy     - multi-cycle operation in progress (RUN state)
//   done     - one-cycle pulse, result valid
//   out_ula  - registered result, 2*WIDTH bits
//   sinal    - subtraction-negative flag
//   err      - divide-by-zero or illegal-op flag
module ula_seq #(
   parameter int unsigned WIDTH = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic [3:0]         op,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] out_ula,
   output logic               sinal,
   output logic               err
);

   localparam int unsigned OW = 2 * WIDTH;
   localparam int unsigned CW = $clog2(WIDTH + 1);

   localparam logic [3:0] OP_ADD = 4'b0001;
   localparam logic [3:0] OP_SUB = 4'b0010;
   localparam logic [3:0] OP_MUL = 4'b0011;
   localparam logic [3:0] OP_AND = 4'b0100;
   localparam logic [3:0] OP_OR  = 4'b0101;
   localparam logic [3:0] OP_XOR = 4'b0110;
   localparam logic [3:0] OP_DIV = 4'b0111;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q,   cnt_d;
   logic [WIDTH-1:0]  a_q,     a_d;
   logic [WIDTH-1:0]  b_q,     b_d;
   logic [3:0]        op_q,    op_d;
   logic [OW-1:0]     acc_q,   acc_d;
   logic [OW-1:0]     out_q,   out_d;
   logic              sinal_q, sinal_d;
   logic              err_q,   err_d;
   logic              busy_q,  busy_d;
   logic              done_q,  done_d;

   // Iteration datapath; acc holds {upper half, lower half} for both algorithms.
   logic [WIDTH:0]    mul_sum_c;
   logic [OW-1:0]     mul_step_c;
   logic [WIDTH:0]    div_trial_c;
   logic              div_fit_c;
   logic [WIDTH-1:0]  div_rem_c;
   logic [OW-1:0]     div_step_c;
   logic [OW-1:0]     step_c;
   logic [WIDTH-1:0]  sub_diff_c;

   // Shift-add multiply: acc = {partial, multiplier}; add multiplicand when the
   // multiplier LSB is set, then shift the whole register right by one.
   always_comb begin
      mul_sum_c  = {1'b0, acc_q[OW-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
      mul_step_c = {mul_sum_c, acc_q[WIDTH-1:1]};
   end

   // Restoring divide: acc = {remainder, dividend/quotient}; shift one dividend
   // bit into the remainder, subtract the divisor when it fits.
   always_comb begin
      div_trial_c = {acc_q[OW-1:WIDTH], acc_q[WIDTH-1]};
      div_fit_c   = (div_trial_c >= {1'b0, b_q});
      div_rem_c   = div_fit_c ? WIDTH'(div_trial_c - {1'b0, b_q})
                              : WIDTH'(div_trial_c);
      div_step_c  = {div_rem_c, acc_q[WIDTH-2:0], div_fit_c};
   end

   always_comb begin
      step_c = (op_q == OP_MUL) ? mul_step_c : div_step_c;
   end

   // Absolute difference for sub.
   always_comb begin
      sub_diff_c = (a >= b) ? (a - b) : (b - a);
   end

   // Next-state and datapath control.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      op_d    = op_q;
      acc_d   = acc_q;
      out_d   = out_q;
      sinal_d = sinal_q;
      err_d   = err_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               a_d  = a;
               b_d  = b;
               op_d = op;
               if (op == OP_MUL) begin
                  acc_d   = OW'(b);
                  cnt_d   = CW'(WIDTH);
                  state_d = S_RUN;
               end else if (op == OP_DIV && b != '0) begin
                  acc_d   = OW'(a);
                  cnt_d   = CW'(WIDTH);
                  state_d = S_RUN;
               end else begin
                  // Everything else completes on the accepting edge.
                  state_d = S_DONE;
                  sinal_d = 1'b0;
                  err_d   = 1'b0;
                  case (op)
                     OP_ADD: out_d = OW'(a) + OW'(b);
                     OP_SUB: begin
                        out_d   = OW'(sub_diff_c);
                        sinal_d = (a < b);
                     end
                     OP_AND: out_d = OW'(a & b);
                     OP_OR:  out_d = OW'(a | b);
                     OP_XOR: out_d = OW'(a ^ b);
                     OP_DIV: begin
                        // Divide by zero: quotient all ones, remainder = a.
                        out_d = {a, {WIDTH{1'b1}}};
                        err_d = 1'b1;
                     end
                     default: begin
                        out_d = '0;
                        err_d = 1'b1;
                     end
                  endcase
               end
            end
         end

         S_RUN: begin
            acc_d = step_c;
            cnt_d = cnt_q - CW'(1);
            // Last iteration: publish the result on this edge.
            if (cnt_q == CW'(1)) begin
               state_d = S_DONE;
               out_d   = step_c;
               sinal_d = 1'b0;
               err_d   = 1'b0;
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d == S_RUN);
      done_d = (state_d == S_DONE);
   end

   // State and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= '0;
         acc_q   <= '0;
         out_q   <= '0;
         sinal_q <= 1'b0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         acc_q   <= acc_d;
         out_q   <= out_d;
         sinal_q <= sinal_d;
         err_q   <= err_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign out_ula = out_q;
   assign sinal   = sinal_q;
   assign err     = err_q;

endmodule

// File: tb/tb_ula_seq.sv
// Testbench for ula_seq (WIDTH=4): scoreboard of expected results pushed when
// an op is issued and popped when done is observed.
module tb_ula_seq;

   localparam int unsigned W  = 4;
   localparam int unsigned OW = 2 * W;

   typedef struct packed {
      logic [OW-1:0] out;
      logic          sinal;
      logic          err;
   } exp_t;

   logic          clk;
   logic          rst;
   logic          start;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic [3:0]    op;
   logic          busy;
   logic          done;
   logic [OW-1:0] out_ula;
   logic          sinal;
   logic          err;

   int   checks;
   int   failures;
   exp_t sb[$];

   ula_seq #(.WIDTH(W)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .a       (a),
      .b       (b),
      .op      (op),
      .busy    (busy),
      .done    (done),
      .out_ula (out_ula),
      .sinal   (sinal),
      .err     (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model from plain integer arithmetic.
   function automatic exp_t model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
      exp_t        r;
      int unsigned ux;
      int unsigned uy;
      r  = '0;
      ux = x;
      uy = y;
      case (o)
         4'd1: r.out = OW'(ux + uy);
         4'd2: begin
            if (ux < uy) begin
               r.out   = OW'(uy - ux);
               r.sinal = 1'b1;
            end else begin
               r.out = OW'(ux - uy);
            end
         end
         4'd3: r.out = OW'(ux * uy);
         4'd4: r.out = OW'(x & y);
         4'd5: r.out = OW'(x | y);
         4'd6: r.out = OW'(x ^ y);
         4'd7: begin
            if (uy == 0) begin
               r.out = OW'((ux << W) | ((1 << W) - 1));
               r.err = 1'b1;
            end else begin
               r.out = OW'(((ux % uy) << W) | (ux / uy));
            end
         end
         default: r.err = 1'b1;
      endcase
      return r;
   endfunction

   // Drive one request so that the next rising edge samples it; returns 1 time
   // unit after that accepting edge with start already low.
   task automatic issue(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input bit expect_result);
      @(negedge clk);
      op    = o;
      a     = x;
      b     = y;
      start = 1'b1;
      if (expect_result) sb.push_back(model(o, x, y));
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic test_reset();
      rst   = 1'b1;
      start = 1'b0;
      a     = '0;
      b     = '0;
      op    = '0;
      #23;
      checks++;
      if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++;
      if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
      checks++;
      if (out_ula !== '0) begin failures++; $display("FAIL reset_out got=%h exp=00", out_ula); end
      checks++;
      if ({sinal, err} !== 2'b00) begin failures++; $display("FAIL reset_flags got=%b exp=00", {sinal, err}); end
      @(negedge clk);
      rst = 1'b0;
   endtask

   // One single-cycle op: done right after the accepting edge, busy never high,
   // done exactly one cycle wide.
   task automatic test_single_op(input string name, input logic [3:0] o,
                                 input logic [W-1:0] x, input logic [W-1:0] y);
      exp_t e;
      issue(o, x, y, 1'b1);
      checks++;
      if (done !== 1'b1 || busy !== 1'b0) begin
         failures++;
         $display("FAIL %s_latency got done=%b busy=%b exp done=1 busy=0", name, done, busy);
      end
      e = sb.pop_front();
      checks++;
      if ({out_ula, sinal, err} !== e) begin
         failures++;
         $display("FAIL %s_result got out=%h sinal=%b err=%b exp out=%h sinal=%b err=%b",
                  name, out_ula, sinal, err, e.out, e.sinal, e.err);
      end
      @(posedge clk);
      #1;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL %s_pulse got done=%b busy=%b exp done=0 busy=0", name, done, busy);
      end
   endtask

   // One multi-cycle op: busy for W cycles, done on the W-th edge after the
   // accepting edge, previous result held throughout RUN.
   task automatic test_multi_op(input string name, input logic [3:0] o,
                                input logic [W-1:0] x, input logic [W-1:0] y);
      exp_t          e;
      logic [OW-1:0] prev;
      int            cyc;
      int            bcnt;
      bit            moved;
      prev  = out_ula;
      moved = 1'b0;
      issue(o, x, y, 1'b1);
      cyc  = 0;
      bcnt = (busy === 1'b1) ? 1 : 0;
      while (done !== 1'b1 && cyc < 4 * W) begin
         if (out_ula !== prev) moved = 1'b1;
         @(posedge clk);
         #1;
         cyc++;
         if (busy === 1'b1) bcnt++;
      end
      checks++;
      if (cyc != W || done !== 1'b1) begin
         failures++;
         $display("FAIL %s_latency got cycles=%0d done=%b exp cycles=%0d done=1", name, cyc, done, W);
      end
      checks++;
      if (bcnt != W) begin failures++; $display("FAIL %s_busy_cycles got=%0d exp=%0d", name, bcnt, W); end
      checks++;
      if (moved) begin failures++; $display("FAIL %s_hold got out changed during run exp held=%h", name, prev); end
      e = sb.pop_front();
      checks++;
      if ({out_ula, sinal, err} !== e) begin
         failures++;
         $display("FAIL %s_result got out=%h sinal=%b err=%b exp out=%h sinal=%b err=%b",
                  name, out_ula, sinal, err, e.out, e.sinal, e.err);
      end
      @(posedge clk);
      #1;
      checks++;
      if (done !== 1'b0) begin failures++; $display("FAIL %s_pulse got done=%b exp=0", name, done); end
   endtask

   // Mul with operands toggled and a start pulse while in RUN.
   task automatic test_mul_inflight();
      exp_t e;
      int   cyc;
      int   extra;
      issue(4'b0011, 4'd15, 4'd15, 1'b1);
      cyc = 0;
      while (done !== 1'b1 && cyc < 4 * W) begin
         if (cyc == 0) begin a = 4'd0; b = 4'd1; op = 4'b0001; start = 1'b1; end
         if (cyc == 1) begin a = 4'd5; b = 4'd2; start = 1'b0; end
         @(posedge clk);
         #1;
         cyc++;
      end
      checks++;
      if (cyc != W) begin failures++; $display("FAIL mul_inflight_latency got=%0d exp=%0d", cyc, W); end
      e = sb.pop_front();
      checks++;
      if ({out_ula, sinal, err} !== e) begin
         failures++;
         $display("FAIL mul_inflight_result got out=%h err=%b exp out=%h err=%b", out_ula, err, e.out, e.err);
      end
      extra = 0;
      for (int i = 0; i < 2 * W; i++) begin
         @(posedge clk);
         #1;
         if (done === 1'b1) extra++;
      end
      checks++;
      if (extra != 0) begin failures++; $display("FAIL mul_start_ignored got extra_done=%0d exp=0", extra); end
   endtask

   // Reset two cycles into a mul: outputs clear at once and no done follows.
   task automatic test_reset_abort();
      int dcnt;
      issue(4'b0011, 4'd6, 4'd5, 1'b0);
      @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b1) begin failures++; $display("FAIL abort_pre_busy got=%b exp=1", busy); end
      rst = 1'b1;
      #1;
      checks++;
      if ({busy, done, out_ula, sinal, err} !== '0) begin
         failures++;
         $display("FAIL abort_clear got busy=%b done=%b out=%h sinal=%b err=%b exp all 0",
                  busy, done, out_ula, sinal, err);
      end
      dcnt = 0;
      repeat (2) begin
         @(posedge clk);
         #1;
         if (done === 1'b1 || busy === 1'b1) dcnt++;
      end
      @(negedge clk);
      rst = 1'b0;
      repeat (2 * W) begin
         @(posedge clk);
         #1;
         if (done === 1'b1 || busy === 1'b1) dcnt++;
      end
      checks++;
      if (dcnt != 0) begin failures++; $display("FAIL abort_no_done got activity=%0d exp=0", dcnt); end
      test_single_op("add_after_rst", 4'b0001, 4'd1, 4'd1);
   endtask

   // start held high with AND: done every second cycle, one cycle wide.
   task automatic test_back_to_back();
      exp_t e;
      int   bad;
      int   bad_res;
      @(negedge clk);
      op    = 4'b0100;
      a     = 4'b1101;
      b     = 4'b0111;
      start = 1'b1;
      bad     = 0;
      bad_res = 0;
      for (int i = 0; i < 12; i++) begin
         if ((i % 2) == 0) sb.push_back(model(op, a, b));
         @(posedge clk);
         #1;
         if (done !== ((i % 2) == 0)) bad++;
         if (done === 1'b1 && sb.size() > 0) begin
            e = sb.pop_front();
            if ({out_ula, sinal, err} !== e) bad_res++;
         end
      end
      start = 1'b0;
      sb.delete();
      checks++;
      if (bad != 0) begin failures++; $display("FAIL b2b_done_pattern got bad_cycles=%0d exp=0", bad); end
      checks++;
      if (bad_res != 0) begin failures++; $display("FAIL b2b_result got bad_results=%0d exp=0", bad_res); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_random();
      logic [3:0]   o;
      logic [W-1:0] x;
      logic [W-1:0] y;
      for (int i = 0; i < 24; i++) begin
         o = 4'($urandom_range(0, 15));
         x = W'($urandom);
         y = W'($urandom_range(0, 3) == 0 ? 0 : $urandom);
         if (o == 4'b0011 || (o == 4'b0111 && y != '0)) test_multi_op("rand_multi", o, x, y);
         else test_single_op("rand_single", o, x, y);
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_single_op("add", 4'b0001, 4'd9, 4'd8);
      test_single_op("sub_neg", 4'b0010, 4'd3, 4'd7);
      test_single_op("sub_pos", 4'b0010, 4'd7, 4'd3);
      test_single_op("and", 4'b0100, 4'b1100, 4'b1010);
      test_single_op("or", 4'b0101, 4'b1100, 4'b1010);
      test_single_op("xor", 4'b0110, 4'b1100, 4'b1010);
      test_multi_op("mul", 4'b0011, 4'd15, 4'd15);
      test_mul_inflight();
      test_multi_op("div", 4'b0111, 4'd13, 4'd4);
      test_single_op("div0", 4'b0111, 4'd13, 4'd0);
      test_multi_op("div_small", 4'b0111, 4'd2, 4'd9);
      test_single_op("illegal_1010", 4'b1010, 4'd5, 4'd6);
      test_single_op("illegal_0000", 4'b0000, 4'd5, 4'd6);
      test_reset_abort();
      test_back_to_back();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
